// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcodes, ALU/PC select codes, control-word layout, FSM states.
// The opcode decode and condition evaluation are helpers so that the immediate generator and the FSM agree.
package legv8_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EX1   = 2'd1,
    S_EX2   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_LSL, OP_LSR, OP_MOVZ,
    OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B, OP_BR, OP_BCOND, OP_BAD
  } op_t;

  // IR[31:21] patterns; '?' marks bits that belong to an immediate field
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [10:0] OPC_AND   = 11'b10001010000;
  localparam logic [10:0] OPC_ORR   = 11'b10101010000;
  localparam logic [10:0] OPC_EOR   = 11'b11001010000;
  localparam logic [10:0] OPC_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OPC_SUBI  = 11'b1101000100?;
  localparam logic [10:0] OPC_ANDI  = 11'b1001001000?;
  localparam logic [10:0] OPC_ORRI  = 11'b1011001000?;
  localparam logic [10:0] OPC_LSL   = 11'b11010011011;
  localparam logic [10:0] OPC_LSR   = 11'b11010011010;
  localparam logic [10:0] OPC_MOVZ  = 11'b110100101??;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ   = 11'b10110100???;
  localparam logic [10:0] OPC_CBNZ  = 11'b10110101???;
  localparam logic [10:0] OPC_B     = 11'b000101?????;
  localparam logic [10:0] OPC_BR    = 11'b11010110000;
  localparam logic [10:0] OPC_BCOND = 11'b01010100???;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSR = 5'b10000;
  localparam logic [4:0] FS_LSL = 5'b10100;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BUS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam int CW_DA     = 0;
  localparam int CW_SA     = 5;
  localparam int CW_SB     = 10;
  localparam int CW_FS     = 15;
  localparam int CW_PS     = 20;
  localparam int CW_WR     = 22;
  localparam int CW_WM     = 23;
  localparam int CW_SL     = 24;
  localparam int CW_BSEL   = 25;
  localparam int CW_PCSEL  = 26;
  localparam int CW_EN_ALU = 27;
  localparam int CW_EN_RAM = 28;
  localparam int CW_EN_PC  = 29;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;

  function automatic op_t decode_op(input logic [10:0] opc);
    op_t op;
    casez (opc)
      OPC_ADD:   op = OP_ADD;
      OPC_ADDS:  op = OP_ADDS;
      OPC_SUB:   op = OP_SUB;
      OPC_SUBS:  op = OP_SUBS;
      OPC_AND:   op = OP_AND;
      OPC_ORR:   op = OP_ORR;
      OPC_EOR:   op = OP_EOR;
      OPC_ADDI:  op = OP_ADDI;
      OPC_SUBI:  op = OP_SUBI;
      OPC_ANDI:  op = OP_ANDI;
      OPC_ORRI:  op = OP_ORRI;
      OPC_LSL:   op = OP_LSL;
      OPC_LSR:   op = OP_LSR;
      OPC_MOVZ:  op = OP_MOVZ;
      OPC_LDUR:  op = OP_LDUR;
      OPC_STUR:  op = OP_STUR;
      OPC_CBZ:   op = OP_CBZ;
      OPC_CBNZ:  op = OP_CBNZ;
      OPC_B:     op = OP_B;
      OPC_BR:    op = OP_BR;
      OPC_BCOND: op = OP_BCOND;
      default:   op = OP_BAD;
    endcase
    return op;
  endfunction

  function automatic logic [4:0] alu_fs(input op_t op);
    logic [4:0] fs;
    case (op)
      OP_ADD, OP_ADDS, OP_ADDI: fs = FS_ADD;
      OP_SUB, OP_SUBS, OP_SUBI: fs = FS_SUB;
      OP_AND, OP_ANDI:          fs = FS_AND;
      OP_EOR:                   fs = FS_EOR;
      OP_LSL:                   fs = FS_LSL;
      OP_LSR:                   fs = FS_LSR;
      default:                  fs = FS_ORR;
    endcase
    return fs;
  endfunction

  // flags = {V,C,N,Z}; codes 14 and 15 are both "always"
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z, t;
    v = flags[3];
    c = flags[2];
    n = flags[1];
    z = flags[0];
    case (cond)
      COND_EQ: t = z;
      COND_NE: t = !z;
      COND_HS: t = c;
      COND_LO: t = !c;
      COND_MI: t = n;
      COND_PL: t = !n;
      COND_VS: t = v;
      COND_VC: t = !v;
      COND_HI: t = c && !z;
      COND_LS: t = !(c && !z);
      COND_GE: t = (n == v);
      COND_LT: t = (n != v);
      COND_GT: t = !z && (n == v);
      COND_LE: t = !(!z && (n == v));
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Combinational immediate generator: selects, extends and shifts the IR immediate field for the decoded format.
// Zero latency; formats without an immediate (R-type, BR, unknown) yield zero.
module legv8_imm_gen
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       ir,
  output logic [DATA_W-1:0] imm
);

  op_t op;
  assign op = decode_op(ir[31:21]);

  always_comb begin
    imm = '0;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: imm[11:0] = ir[21:10];
      OP_LSL, OP_LSR:                     imm[5:0]  = ir[15:10];
      // hw selects a 16-bit lane: shift by 0, 16, 32 or 48
      OP_MOVZ:                  imm = {{(DATA_W-16){1'b0}}, ir[20:5]} << {ir[22:21], 4'b0000};
      OP_LDUR, OP_STUR:         imm = {{(DATA_W-9){ir[20]}}, ir[20:12]};
      OP_CBZ, OP_CBNZ, OP_BCOND: imm = {{(DATA_W-19){ir[23]}}, ir[23:5]};
      OP_B:                     imm = {{(DATA_W-26){ir[25]}}, ir[25:0]};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH latches the IR, EX1/EX2 drive the datapath control word and constant.
// Outputs are combinational from state/IR/status; an unknown opcode parks the FSM in HALT until reset.
module legv8_control_fsm
  import legv8_pkg::*;
#(
  parameter int CW_W   = 30,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  output logic [CW_W-1:0]   control_word,
  output logic [DATA_W-1:0] constant,
  output logic [1:0]        state,
  output logic              halted
);

  state_t            st, st_nxt;
  logic [31:0]       ir;
  logic              zflag;
  op_t               op;
  logic [DATA_W-1:0] imm;
  logic [CW_W-1:0]   cw;
  logic [4:0]        da, sa, sb, fs;
  logic [1:0]        ps;
  logic              wr, wm, sl, bsel, en_alu, en_ram;

  assign op = decode_op(ir[31:21]);

  legv8_imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= S_FETCH;
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == S_FETCH) ir <= instruction;
      // CB compares Rt|XZR in EX1; the branch decision is taken in EX2
      if (st == S_EX1 && (op == OP_CBZ || op == OP_CBNZ)) zflag <= status[0];
    end
  end

  always_comb begin
    st_nxt = st;
    da = '0; sa = '0; sb = '0; fs = '0; ps = PS_HOLD;
    wr = 1'b0; wm = 1'b0; sl = 1'b0; bsel = 1'b0; en_alu = 1'b0; en_ram = 1'b0;
    case (st)
      S_FETCH: st_nxt = S_EX1;
      S_EX1: begin
        st_nxt = S_FETCH;
        case (op)
          OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR,
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_LSL, OP_LSR, OP_MOVZ: begin
            da     = ir[4:0];
            sa     = (op == OP_MOVZ) ? 5'd31 : ir[9:5];
            sb     = ir[20:16];
            fs     = alu_fs(op);
            en_alu = 1'b1;
            wr     = 1'b1;
            ps     = PS_INC;
            sl     = (op == OP_ADDS) || (op == OP_SUBS);
            bsel   = !(op inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR});
          end
          OP_LDUR: begin
            sa = ir[9:5]; bsel = 1'b1; fs = FS_ADD;
            st_nxt = S_EX2;
          end
          OP_STUR: begin
            sa = ir[9:5]; bsel = 1'b1; fs = FS_ADD;
            sb = ir[4:0]; wm = 1'b1; ps = PS_INC;
          end
          OP_CBZ, OP_CBNZ: begin
            sa = ir[4:0]; sb = 5'd31; fs = FS_ORR;
            st_nxt = S_EX2;
          end
          OP_B:     ps = PS_REL;
          OP_BR: begin
            sa = ir[9:5]; sb = 5'd31; fs = FS_ORR; en_alu = 1'b1; ps = PS_BUS;
          end
          OP_BCOND: ps = cond_true(ir[3:0], status[4:1]) ? PS_REL : PS_INC;
          default:  st_nxt = S_HALT;
        endcase
      end
      S_EX2: begin
        st_nxt = S_FETCH;
        case (op)
          OP_LDUR: begin
            sa = ir[9:5]; bsel = 1'b1; fs = FS_ADD;
            en_ram = 1'b1; wr = 1'b1; da = ir[4:0]; ps = PS_INC;
          end
          OP_CBZ, OP_CBNZ: begin
            sa = ir[4:0]; sb = 5'd31; fs = FS_ORR;
            ps = (zflag ^ (op == OP_CBNZ)) ? PS_REL : PS_INC;
          end
          default: ps = PS_INC;
        endcase
      end
      default: st_nxt = S_HALT;
    endcase

    cw                = '0;
    cw[CW_DA +: 5]    = da;
    cw[CW_SA +: 5]    = sa;
    cw[CW_SB +: 5]    = sb;
    cw[CW_FS +: 5]    = fs;
    cw[CW_PS +: 2]    = ps;
    cw[CW_WR]         = wr;
    cw[CW_WM]         = wm;
    cw[CW_SL]         = sl;
    cw[CW_BSEL]       = bsel;
    cw[CW_EN_ALU]     = en_alu;
    cw[CW_EN_RAM]     = en_ram;
    // PC sequencing goes entirely through PS, so these two stay idle
    cw[CW_PCSEL]      = 1'b0;
    cw[CW_EN_PC]      = 1'b0;
  end

  // reset masks the outputs in the same cycle so an aborted EX2 never writes
  assign control_word = reset ? '0 : cw;
  assign constant     = (!reset && (st == S_EX1 || st == S_EX2)) ? imm : '0;
  assign state        = st;
  assign halted       = (st == S_HALT);

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Bench for legv8_control_fsm: directed scenarios with literal expectations plus random instruction streams.
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [29:0] control_word;
  logic [63:0] constant;
  logic [1:0]  state;
  logic        halted;
  int checks = 0;
  int failures = 0;

  legv8_control_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .state        (state),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic string mnem(input logic [31:0] ir);
    if (ir[31:26] == 6'b000101) return "B";
    if (ir[31:24] == 8'h54) return "BCOND";
    if (ir[31:24] == 8'hB4) return "CBZ";
    if (ir[31:24] == 8'hB5) return "CBNZ";
    if (ir[31:23] == 9'b110100101) return "MOVZ";
    if (ir[31:22] == 10'b1001000100) return "ADDI";
    if (ir[31:22] == 10'b1101000100) return "SUBI";
    if (ir[31:22] == 10'b1001001000) return "ANDI";
    if (ir[31:22] == 10'b1011001000) return "ORRI";
    if (ir[31:21] == 11'h458) return "ADD";
    if (ir[31:21] == 11'h558) return "ADDS";
    if (ir[31:21] == 11'h658) return "SUB";
    if (ir[31:21] == 11'h758) return "SUBS";
    if (ir[31:21] == 11'h450) return "AND";
    if (ir[31:21] == 11'h550) return "ORR";
    if (ir[31:21] == 11'h650) return "EOR";
    if (ir[31:21] == 11'h69B) return "LSL";
    if (ir[31:21] == 11'h69A) return "LSR";
    if (ir[31:21] == 11'h7C2) return "LDUR";
    if (ir[31:21] == 11'h7C0) return "STUR";
    if (ir[31:21] == 11'h6B0) return "BR";
    return "BAD";
  endfunction

  function automatic int fs_of(input string m);
    if (m == "ADD" || m == "ADDS" || m == "ADDI") return 8;
    if (m == "SUB" || m == "SUBS" || m == "SUBI") return 9;
    if (m == "AND" || m == "ANDI") return 0;
    if (m == "EOR") return 12;
    if (m == "LSR") return 16;
    if (m == "LSL") return 20;
    return 4;
  endfunction

  // flags arrive as {V,C,N,Z}; pairs of codes are a base test and its negation
  function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
    bit v, c, n, z, base;
    v = f[3]; c = f[2]; n = f[1]; z = f[0];
    case (cond >> 1)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond[0] && cond != 4'd15) return !base;
    return base;
  endfunction

  task automatic model(input logic [31:0] ir, input int phase, input logic [4:0] stat,
                       input bit zf, output logic [29:0] cw, output logic [63:0] k, output int nph);
    string m;
    int da, sa, sb, fs, ps, wr, wm, sl, bsel, ea, er, w;
    bit rtype, itype, shift;
    longint kk;
    m = mnem(ir);
    da = 0; sa = 0; sb = 0; fs = 0; ps = 0; wr = 0; wm = 0; sl = 0; bsel = 0; ea = 0; er = 0;
    kk = 0; nph = 1;
    rtype = (m == "ADD" || m == "ADDS" || m == "SUB" || m == "SUBS" || m == "AND" || m == "ORR" || m == "EOR");
    itype = (m == "ADDI" || m == "SUBI" || m == "ANDI" || m == "ORRI");
    shift = (m == "LSL" || m == "LSR");
    if (rtype || itype || shift || m == "MOVZ") begin
      da = ir[4:0]; sa = (m == "MOVZ") ? 31 : ir[9:5]; sb = ir[20:16];
      ea = 1; wr = 1; ps = 1; fs = fs_of(m);
      sl = (m == "ADDS" || m == "SUBS") ? 1 : 0;
      bsel = rtype ? 0 : 1;
      if (itype) kk = ir[21:10];
      else if (shift) kk = ir[15:10];
      else if (m == "MOVZ") kk = ir[20:5] * (longint'(1) << (16 * ir[22:21]));
    end else if (m == "LDUR" || m == "STUR") begin
      sa = ir[9:5]; bsel = 1; fs = 8;
      kk = longint'($signed(ir[20:12]));
      if (m == "STUR") begin
        sb = ir[4:0]; wm = 1; ps = 1;
      end else begin
        nph = 2;
        if (phase == 2) begin er = 1; wr = 1; da = ir[4:0]; ps = 1; end
      end
    end else if (m == "CBZ" || m == "CBNZ") begin
      nph = 2; sa = ir[4:0]; sb = 31; fs = 4;
      kk = longint'($signed(ir[23:5]));
      if (phase == 2) ps = ((zf ? 1 : 0) ^ (m == "CBNZ" ? 1 : 0)) ? 3 : 1;
    end else if (m == "B") begin
      ps = 3; kk = longint'($signed(ir[25:0]));
    end else if (m == "BR") begin
      sa = ir[9:5]; sb = 31; fs = 4; ea = 1; ps = 2;
    end else if (m == "BCOND") begin
      kk = longint'($signed(ir[23:5]));
      ps = cond_holds(ir[3:0], stat[4:1]) ? 3 : 1;
    end
    w = da + sa * 32 + sb * 1024 + fs * (1 << 15) + ps * (1 << 20) + wr * (1 << 22) + wm * (1 << 23)
        + sl * (1 << 24) + bsel * (1 << 25) + ea * (1 << 27) + er * (1 << 28);
    cw = w[29:0];
    k = kk;
  endtask

  function automatic logic [31:0] gen_instr(input int sel, input logic [31:0] r);
    case (sel)
      0:  return {11'h458, r[20:0]};
      1:  return {11'h558, r[20:0]};
      2:  return {11'h658, r[20:0]};
      3:  return {11'h758, r[20:0]};
      4:  return {11'h450, r[20:0]};
      5:  return {11'h550, r[20:0]};
      6:  return {11'h650, r[20:0]};
      7:  return {10'b1001000100, r[21:0]};
      8:  return {10'b1101000100, r[21:0]};
      9:  return {10'b1001001000, r[21:0]};
      10: return {10'b1011001000, r[21:0]};
      11: return {11'h69B, r[20:0]};
      12: return {11'h69A, r[20:0]};
      13: return {9'b110100101, r[22:0]};
      14: return {11'h7C2, r[20:0]};
      15: return {11'h7C0, r[20:0]};
      16: return {8'hB4, r[23:0]};
      17: return {8'hB5, r[23:0]};
      18: return {6'b000101, r[25:0]};
      19: return {11'h6B0, r[20:0]};
      default: return {8'h54, r[23:0]};
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; instruction = $urandom; status = 5'h1F;
    step(); step();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (control_word !== 30'd0) begin failures++; $display("FAIL reset_cw got=%h want=0", control_word); end
    checks++; if (constant !== 64'd0) begin failures++; $display("FAIL reset_const got=%h want=0", constant); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", halted); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    instruction = 32'h8B020020; status = 5'd0; #1;
    checks++; if (control_word !== 30'd0) begin failures++; $display("FAIL add_fetch_cw got=%h want=0", control_word); end
    step(); instruction = $urandom; #1;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL add_ex1_state got=%0d want=1", state); end
    checks++; if (control_word !== 30'h8540820) begin failures++; $display("FAIL add_ex1_cw got=%h want=08540820", control_word); end
    step(); #1;
    checks++; if (state !== 2'd0 || control_word !== 30'd0) begin failures++; $display("FAIL add_back_fetch state=%0d cw=%h want state=0 cw=0", state, control_word); end
  endtask

  task automatic test_ldur();
    instruction = 32'hF85F8083; step(); instruction = $urandom; #1;
    checks++; if (constant !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL ldur_const got=%h want=fffffffffffffff8", constant); end
    checks++; if (control_word[25] !== 1'b1 || control_word[22] !== 1'b0 || control_word[21:20] !== 2'b00 || control_word[9:5] !== 5'd4)
      begin failures++; $display("FAIL ldur_ex1_cw got=%h want bsel=1 wr=0 ps=0 sa=4", control_word); end
    step(); #1;
    checks++; if (state !== 2'd2 || control_word[28] !== 1'b1 || control_word[22] !== 1'b1 || control_word[4:0] !== 5'd3 || control_word[21:20] !== 2'b01)
      begin failures++; $display("FAIL ldur_ex2 state=%0d cw=%h want state=2 en_ram=1 wr=1 da=3 ps=1", state, control_word); end
    step();
  endtask

  task automatic test_cbz();
    for (int z = 1; z >= 0; z--) begin
      instruction = 32'hB4000065; status = 5'd0; step();
      status = {4'b0000, z[0]}; #1;
      checks++; if (control_word[21:20] !== 2'b00 || control_word[9:5] !== 5'd5)
        begin failures++; $display("FAIL cbz_ex1 z=%0d cw=%h want ps=0 sa=5", z, control_word); end
      step();
      status = {4'b1111, ~z[0]}; #1;
      checks++; if (control_word[21:20] !== (z ? 2'b11 : 2'b01) || control_word[22] !== 1'b0)
        begin failures++; $display("FAIL cbz_ex2_ps z=%0d got=%b want=%b", z, control_word[21:20], (z ? 2'b11 : 2'b01)); end
      checks++; if (constant !== 64'd3) begin failures++; $display("FAIL cbz_ex2_const got=%h want=3", constant); end
      step();
    end
  endtask

  task automatic test_bcond();
    for (int t = 0; t < 2; t++) begin
      instruction = 32'h5400004A; status = 5'd0; step();
      status = t ? 5'b10100 : 5'b10000; #1;
      checks++; if (control_word[21:20] !== (t ? 2'b11 : 2'b01))
        begin failures++; $display("FAIL bge_ps status=%b got=%b want=%b", status, control_word[21:20], (t ? 2'b11 : 2'b01)); end
      checks++; if (constant !== 64'd2) begin failures++; $display("FAIL bge_const got=%h want=2", constant); end
      step();
    end
  endtask

  task automatic test_movz();
    instruction = 32'hD2A24687; status = 5'd0; step(); #1;
    checks++; if (constant !== 64'h12340000) begin failures++; $display("FAIL movz_const got=%h want=12340000", constant); end
    checks++; if (control_word[9:5] !== 5'd31 || control_word[25] !== 1'b1 || control_word[4:0] !== 5'd7 || control_word[22] !== 1'b1)
      begin failures++; $display("FAIL movz_cw got=%h want sa=31 bsel=1 da=7 wr=1", control_word); end
    step();
  endtask

  task automatic test_random_stream();
    logic [31:0] ir;
    logic [29:0] ecw;
    logic [63:0] ek;
    logic [4:0]  s;
    int nph;
    bit zf;
    for (int n = 0; n < 250; n++) begin
      ir = gen_instr($urandom_range(0, 20), $urandom);
      instruction = ir; status = $urandom; #1;
      checks++; if (state !== 2'd0 || control_word !== 30'd0 || constant !== 64'd0)
        begin failures++; $display("FAIL rnd_fetch ir=%h state=%0d cw=%h k=%h want 0/0/0", ir, state, control_word, constant); end
      step();
      zf = 1'b0; nph = 1;
      for (int ph = 1; ph <= nph; ph++) begin
        s = $urandom; status = s; instruction = $urandom; #1;
        model(ir, ph, s, zf, ecw, ek, nph);
        if (ph == 1) zf = s[0];
        checks++; if (state !== 2'(ph)) begin failures++; $display("FAIL rnd_state ir=%h ph=%0d got=%0d want=%0d", ir, ph, state, ph); end
        checks++; if (control_word !== ecw) begin failures++; $display("FAIL rnd_cw ir=%h ph=%0d st=%b got=%h want=%h", ir, ph, s, control_word, ecw); end
        checks++; if (constant !== ek) begin failures++; $display("FAIL rnd_const ir=%h ph=%0d got=%h want=%h", ir, ph, constant, ek); end
        step();
      end
    end
  endtask

  task automatic test_halt();
    instruction = 32'h0000_0000; step(); #1;
    checks++; if (control_word !== 30'd0 || constant !== 64'd0) begin failures++; $display("FAIL halt_ex1 cw=%h k=%h want 0", control_word, constant); end
    step();
    for (int i = 0; i < 10; i++) begin
      instruction = $urandom; status = $urandom; #1;
      checks++; if (state !== 2'd3 || halted !== 1'b1 || control_word !== 30'd0 || constant !== 64'd0)
        begin failures++; $display("FAIL halt_hold cyc=%0d state=%0d halted=%b cw=%h k=%h want 3/1/0/0", i, state, halted, control_word, constant); end
      step();
    end
    reset = 1'b1; step(); reset = 1'b0; #1;
    checks++; if (state !== 2'd0 || halted !== 1'b0) begin failures++; $display("FAIL halt_reset state=%0d halted=%b want 0/0", state, halted); end
  endtask

  task automatic test_reset_mid_ex2();
    instruction = 32'hF85F8083; status = 5'd0; step(); step(); #1;
    checks++; if (control_word[22] !== 1'b1) begin failures++; $display("FAIL ex2_live_wr got=%b want=1", control_word[22]); end
    reset = 1'b1; #1;
    checks++; if (control_word !== 30'd0 || constant !== 64'd0) begin failures++; $display("FAIL ex2_abort cw=%h k=%h want 0", control_word, constant); end
    step(); reset = 1'b0; #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL ex2_abort_state got=%0d want=0", state); end
  endtask

  initial begin
    reset = 1'b1; instruction = '0; status = '0;
    test_reset();
    test_add();
    test_ldur();
    test_cbz();
    test_bcond();
    test_movz();
    test_random_stream();
    test_halt();
    test_reset_mid_ex2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
